// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: turns one player's raw up/down push-buttons into
// single-cycle paddle step strobes, with sync, debounce and rate limiting.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   btn_up   in   raw "move up" button, active-high, asynchronous
//   btn_down in   raw "move down" button, active-high, asynchronous
//   up       out  one-cycle up step strobe (one pixel)
//   down     out  one-cycle down step strobe (one pixel)
//   up_db    out  debounced btn_up level
//   down_db  out  debounced btn_down level
//   fast     out  high while the step rate is accelerated
//
// Build option: define PADDLE_ACCEL_EN to enable the accelerated FAST
// state. Without it the step period stays STEP_DIV for the whole hold
// and fast is tied low.

module paddle_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_DIV        = 416666,
  parameter int ACCEL_STEPS     = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic up_db,
  output logic down_db,
  output logic fast
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = $clog2(STEP_DIV);

  localparam logic [DW-1:0] DB_TERM =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SLOW_TERM =
    SW'(STEP_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SLOW = 2'd1;

`ifdef PADDLE_ACCEL_EN
  localparam int AW = $clog2(ACCEL_STEPS + 1);
  localparam logic [1:0] S_FAST = 2'd2;
  localparam logic [SW-1:0] FAST_TERM =
    SW'(STEP_DIV / 2 - 1);
  localparam logic [AW-1:0] ACC_TERM =
    AW'(ACCEL_STEPS);
`endif

  // ---------------- sync + debounce ----------------
  // index 0 = up button, index 1 = down button
  logic [1:0]    w_raw;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_db;
  logic [DW-1:0] r_dbc [2];

  assign w_raw = {btn_down, btn_up};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_db <= '0;
      for (int i = 0; i < 2; i++) begin
        r_dbc[i] <= '0;
      end
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_db[i]) begin
          // any return to the accepted level restarts the count
          r_dbc[i] <= '0;
        end else if (r_dbc[i] == DB_TERM) begin
          r_db[i]  <= ~r_db[i];
          r_dbc[i] <= '0;
        end else begin
          r_dbc[i] <= r_dbc[i] + DW'(1);
        end
      end
    end
  end

  // ---------------- direction decode ----------------
  logic w_req_up;
  logic w_req_dn;
  logic w_hold;

  assign w_req_up = r_db[0] & ~r_db[1];
  assign w_req_dn = r_db[1] & ~r_db[0];

  // ---------------- step FSM ----------------
  logic [1:0]    r_state;
  logic          r_dir;   // 0 = up, 1 = down
  logic [SW-1:0] r_step;
  logic          r_up;
  logic          r_dn;

  logic [1:0]    w_nstate;
  logic          w_ndir;
  logic [SW-1:0] w_nstep;
  logic [SW-1:0] w_term;
  logic          w_nup;
  logic          w_ndn;

`ifdef PADDLE_ACCEL_EN
  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_nacc;
  logic [AW-1:0] w_acc_inc;

  assign w_acc_inc = r_acc + AW'(1);
  assign w_term =
    (r_state == S_FAST) ? FAST_TERM : SLOW_TERM;
`else
  assign w_term = SLOW_TERM;
`endif

  // the latched direction is still the only button held
  assign w_hold = r_dir ? w_req_dn : w_req_up;

  always_comb begin
    w_nstate = r_state;
    w_ndir   = r_dir;
    w_nstep  = r_step;
    w_nup    = 1'b0;
    w_ndn    = 1'b0;
`ifdef PADDLE_ACCEL_EN
    w_nacc   = r_acc;
`endif
    case (r_state)
      S_IDLE: begin
        w_nstep = '0;
`ifdef PADDLE_ACCEL_EN
        w_nacc  = AW'(1);
`endif
        if (w_req_up | w_req_dn) begin
          // first step fires on the exit cycle
          w_ndir   = w_req_dn;
          w_nup    = w_req_up;
          w_ndn    = w_req_dn;
          w_nstate = S_SLOW;
`ifdef PADDLE_ACCEL_EN
          if (AW'(1) == ACC_TERM) begin
            w_nstate = S_FAST;
            w_nacc   = '0;
          end
`endif
        end
      end
      default: begin
        if (!w_hold) begin
          // release, chord or reversal: idle one cycle
          w_nstate = S_IDLE;
          w_nstep  = '0;
        end else if (r_step == w_term) begin
          w_nup   = ~r_dir;
          w_ndn   = r_dir;
          w_nstep = '0;
`ifdef PADDLE_ACCEL_EN
          if (r_state == S_SLOW) begin
            if (w_acc_inc == ACC_TERM) begin
              w_nstate = S_FAST;
              w_nacc   = '0;
            end else begin
              w_nacc = w_acc_inc;
            end
          end
`endif
        end else begin
          w_nstep = r_step + SW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_step  <= '0;
      r_up    <= 1'b0;
      r_dn    <= 1'b0;
`ifdef PADDLE_ACCEL_EN
      r_acc   <= '0;
`endif
    end else begin
      r_state <= w_nstate;
      r_dir   <= w_ndir;
      r_step  <= w_nstep;
      r_up    <= w_nup;
      r_dn    <= w_ndn;
`ifdef PADDLE_ACCEL_EN
      r_acc   <= w_nacc;
`endif
    end
  end

  // ---------------- outputs ----------------
  assign up      = r_up;
  assign down    = r_dn;
  assign up_db   = r_db[0];
  assign down_db = r_db[1];

`ifdef PADDLE_ACCEL_EN
  assign fast = (r_state == S_FAST);
`else
  assign fast = 1'b0;
`endif

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl: table-driven check of paddle_input_ctrl
// with DEBOUNCE_CYCLES=4, STEP_DIV=8, ACCEL_STEPS=3.

module tb_paddle_input_ctrl;

  localparam int DB = 4;
  localparam int SD = 8;
  localparam int AS = 3;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic btn_up   = 1'b0;
  logic btn_down = 1'b0;
  logic up;
  logic down;
  logic up_db;
  logic down_db;
  logic fast;

  int checks = 0;
  int errors = 0;

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .STEP_DIV(SD),
    .ACCEL_STEPS(AS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .up(up),
    .down(down),
    .up_db(up_db),
    .down_db(down_db),
    .fast(fast)
  );

  always #5 clock = ~clock;

  // entry t: inputs sampled by edge t, outputs seen just before edge t
  typedef struct {
    logic b_up;
    logic b_dn;
    logic e_up;
    logic e_dn;
    logic e_udb;
    logic e_ddb;
    logic e_fast;
  } vec_t;

  vec_t vec [80];

  task automatic clr();
    for (int i = 0; i < 80; i++) begin
      vec[i] = '{default: 1'b0};
    end
  endtask

  task automatic in_up(input int a, input int b);
    for (int i = a; i <= b; i++) vec[i].b_up = 1'b1;
  endtask

  task automatic in_dn(input int a, input int b);
    for (int i = a; i <= b; i++) vec[i].b_dn = 1'b1;
  endtask

  task automatic udb(input int a, input int b);
    for (int i = a; i <= b; i++) vec[i].e_udb = 1'b1;
  endtask

  task automatic ddb(input int a, input int b);
    for (int i = a; i <= b; i++) vec[i].e_ddb = 1'b1;
  endtask

  task automatic fst(input int a, input int b);
    for (int i = a; i <= b; i++) vec[i].e_fast = 1'b1;
  endtask

  task automatic chk(input string nm, input int t,
                     input logic [4:0] act,
                     input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got {up,dn,udb,ddb,fast}=%b want %b",
               nm, t, act, exp);
    end
  endtask

  // called at a negedge; returns at a negedge
  task automatic run_vec(input string nm, input int n);
    for (int t = 0; t <= n; t++) begin
      btn_up   = vec[t].b_up;
      btn_down = vec[t].b_dn;
      chk(nm, t, {up, down, up_db, down_db, fast},
          {vec[t].e_up, vec[t].e_dn, vec[t].e_udb,
           vec[t].e_ddb, vec[t].e_fast});
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (2) @(negedge clock);
    chk("in_reset", 0, {up, down, up_db, down_db, fast}, 5'b0);
    reset = 1'b0;
  endtask

  initial begin
    // reset release, buttons idle
    do_reset();
    clr();
    run_vec("idle", 50);

    // 3-cycle glitch never accepted
    do_reset();
    clr();
    in_up(0, 2);
    run_vec("glitch", 42);

    // exactly DEBOUNCE_CYCLES long press is accepted, then released
    do_reset();
    clr();
    in_up(0, 3);
    udb(6, 9);
    vec[7].e_up = 1'b1;
    run_vec("db_edge", 20);

    // sustained hold
    do_reset();
    clr();
    in_up(0, 40);
    udb(6, 40);
    vec[7].e_up  = 1'b1;
    vec[15].e_up = 1'b1;
    vec[23].e_up = 1'b1;
`ifdef PADDLE_ACCEL_EN
    vec[27].e_up = 1'b1;
    vec[31].e_up = 1'b1;
    vec[35].e_up = 1'b1;
    vec[39].e_up = 1'b1;
    fst(23, 40);
`else
    vec[31].e_up = 1'b1;
    vec[39].e_up = 1'b1;
`endif
    run_vec("hold", 40);

    // async reset mid-hold, button still pressed
`ifdef PADDLE_ACCEL_EN
    chk("pre_rst", 41, {up, down, up_db, down_db, fast}, 5'b00101);
`else
    chk("pre_rst", 41, {up, down, up_db, down_db, fast}, 5'b00100);
`endif
    #2 reset = 1'b1;
    #1 chk("async_rst", 41, {up, down, up_db, down_db, fast}, 5'b0);
    repeat (2) @(negedge clock);
    chk("rst_held", 43, {up, down, up_db, down_db, fast}, 5'b0);
    reset = 1'b0;
    clr();
    in_up(0, 12);
    udb(6, 12);
    vec[7].e_up = 1'b1;
    run_vec("rst_rehold", 12);

    // chord blocks motion, release resumes with immediate step
    do_reset();
    clr();
    in_up(0, 64);
    in_dn(20, 39);
    udb(6, 64);
    ddb(26, 45);
    vec[7].e_up  = 1'b1;
    vec[15].e_up = 1'b1;
    vec[23].e_up = 1'b1;
    vec[47].e_up = 1'b1;
    vec[55].e_up = 1'b1;
    vec[63].e_up = 1'b1;
`ifdef PADDLE_ACCEL_EN
    fst(23, 26);
    fst(63, 64);
`endif
    run_vec("chord", 64);

    // direct reversal costs one idle cycle
    do_reset();
    clr();
    in_up(0, 11);
    in_dn(12, 29);
    udb(6, 17);
    ddb(18, 29);
    vec[7].e_up  = 1'b1;
    vec[15].e_up = 1'b1;
    vec[20].e_dn = 1'b1;
    vec[28].e_dn = 1'b1;
    run_vec("reverse", 29);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
